// File: rtl/openfire_exc_ctrl_pkg.sv
// Shared constants for the OpenFire exception controller: MSR/ESR bit
// positions, exception codes, link registers and FSM state encoding.
package openfire_exc_ctrl_pkg;

    // MSR bit positions
    localparam int MSR_IE  = 1;
    localparam int MSR_C   = 2;
    localparam int MSR_BIP = 3;
    localparam int MSR_EE  = 8;
    localparam int MSR_EIP = 9;
    localparam int MSR_CM  = 31;

    localparam logic [31:0] MSR_RESET = 32'h0000_0102;

    // ESR fields
    localparam logic [4:0] ESR_EC_ALIGN  = 5'd1;
    localparam logic [4:0] ESR_EC_OPCODE = 5'd2;
    localparam int         ESR_DS        = 12;

    // Link registers used by the inserted "brali rL,vector"
    localparam logic [4:0] LINK_INT = 5'd14;
    localparam logic [4:0] LINK_EXC = 5'd17;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_INT_REQ = 2'd1,
        ST_EXC_REQ = 2'd2
    } exc_state_e;

endpackage

// File: rtl/openfire_irq_prio.sv
// Interrupt source conditioning: per-line edge/level pending logic and a
// lowest-index-wins priority encoder. Edge capture keeps running while the
// pipeline is stalled so that short pulses are never lost.
module openfire_irq_prio #(
    parameter int                 NUM_IRQ  = 4,
    parameter int                 IRQ_ID_W = 2,
    parameter logic [NUM_IRQ-1:0] IRQ_EDGE = '0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_IRQ-1:0]  irq,
    input  logic                take,
    output logic                any_active,
    output logic [IRQ_ID_W-1:0] winner
);

    logic [NUM_IRQ-1:0] irq_prev_q, irq_prev_d;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] active;
    logic [NUM_IRQ-1:0] clr;

    // Edge lines present their latched pending bit, level lines the raw wire.
    always_comb begin
        active = (pending_q & IRQ_EDGE) | (irq & ~IRQ_EDGE);
    end

    // Lowest index wins: scan downwards so the last hit is the smallest index.
    always_comb begin
        winner = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (active[i]) begin
                winner = IRQ_ID_W'(i);
            end
        end
        any_active = |active;
    end

    // Pending bits clear only for the edge line actually taken; a fresh rise
    // in the same cycle re-arms it.
    always_comb begin
        clr = '0;
        if (take) begin
            clr[winner] = 1'b1;
        end
        irq_prev_d = irq;
        pending_d  = ((pending_q & ~(clr & IRQ_EDGE)) | (irq & ~irq_prev_q)) & IRQ_EDGE;
    end

    // Edge-capture state, sampled every cycle regardless of stall.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            irq_prev_q <= '0;
            pending_q  <= '0;
        end else begin
            irq_prev_q <= irq_prev_d;
            pending_q  <= pending_d;
        end
    end

endmodule

// File: rtl/openfire_exc_ctrl.sv
// EXECUTE-stage interrupt/exception controller. Owns MSR, ESR and EAR and asks
// DECODE to insert "brali rL,vector", holding the request until acknowledged.
// Build option: OPENFIRE_VECTORED_IRQ_EN selects per-line interrupt vectors
// (IRQ_VEC_BASE + 8*irq_id); otherwise every interrupt uses INT_VECTOR.
module openfire_exc_ctrl
    import openfire_exc_ctrl_pkg::*;
#(
    parameter int                 NUM_IRQ      = 4,
    parameter int                 IRQ_ID_W     = 2,
    parameter logic [NUM_IRQ-1:0] IRQ_EDGE     = '0,
    parameter int                 ADDR_W       = 32,
    parameter logic [ADDR_W-1:0]  INT_VECTOR   = 'h10,
    parameter logic [ADDR_W-1:0]  IRQ_VEC_BASE = 'h50,
    parameter logic [ADDR_W-1:0]  EXC_VECTOR   = 'h20
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                stall,
    input  logic [NUM_IRQ-1:0]  irq,
    input  logic                exc_align,
    input  logic                exc_opcode,
    input  logic [ADDR_W-1:0]   exc_addr,
    input  logic                in_delay_slot,
    input  logic                msr_wr,
    input  logic [31:0]         msr_wdata,
    input  logic                carry_we,
    input  logic                carry_val,
    input  logic                brk,
    input  logic                rtbd,
    input  logic                rtid,
    input  logic                rted,
    input  logic                insert_ack,
    output logic                insert_req,
    output logic [ADDR_W-1:0]   insert_vector,
    output logic [4:0]          insert_link,
    output logic [IRQ_ID_W-1:0] irq_id,
    output logic [31:0]         msr,
    output logic [31:0]         esr,
    output logic [ADDR_W-1:0]   ear,
    output logic [1:0]          dbg_state
);

`ifdef OPENFIRE_VECTORED_IRQ_EN
    localparam bit VECTORED = 1'b1;
`else
    localparam bit VECTORED = 1'b0;
`endif

    exc_state_e          state_q, state_d;
    logic                req_q, req_d;
    logic [ADDR_W-1:0]   vec_q, vec_d;
    logic [4:0]          link_q, link_d;
    logic [IRQ_ID_W-1:0] id_q, id_d;
    logic [31:0]         msr_q, msr_d;
    logic [31:0]         esr_q, esr_d;
    logic [ADDR_W-1:0]   ear_q, ear_d;

    logic                any_active;
    logic [IRQ_ID_W-1:0] winner;
    logic                idle, exc_any, exc_take, int_take, ack;
    logic [ADDR_W-1:0]   int_vec;

    openfire_irq_prio #(
        .NUM_IRQ  (NUM_IRQ),
        .IRQ_ID_W (IRQ_ID_W),
        .IRQ_EDGE (IRQ_EDGE)
    ) u_prio (
        .clock      (clock),
        .reset      (reset),
        .irq        (irq),
        .take       (int_take),
        .any_active (any_active),
        .winner     (winner)
    );

    // Event qualification: exceptions beat interrupts, nothing moves on stall.
    always_comb begin
        idle     = (state_q == ST_IDLE);
        exc_any  = exc_align | exc_opcode;
        exc_take = ~stall & idle & exc_any & msr_q[MSR_EE] & ~msr_q[MSR_EIP];
        int_take = ~stall & idle & ~exc_any & any_active & msr_q[MSR_IE]
                 & ~msr_q[MSR_EIP] & ~msr_q[MSR_BIP];
        ack      = ~stall & ~idle & insert_ack;
        int_vec  = VECTORED ? (IRQ_VEC_BASE + {{(ADDR_W-IRQ_ID_W-3){1'b0}}, winner, 3'b000})
                            : INT_VECTOR;
    end

    // Request FSM next state; request, vector, link and id are registered.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        vec_d   = vec_q;
        link_d  = link_q;
        id_d    = id_q;
        case (state_q)
            ST_IDLE: begin
                if (exc_take) begin
                    state_d = ST_EXC_REQ;
                    req_d   = 1'b1;
                    vec_d   = EXC_VECTOR;
                    link_d  = LINK_EXC;
                end else if (int_take) begin
                    state_d = ST_INT_REQ;
                    req_d   = 1'b1;
                    vec_d   = int_vec;
                    link_d  = LINK_INT;
                    id_d    = winner;
                end
            end
            ST_INT_REQ, ST_EXC_REQ: begin
                if (ack) begin
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // MSR/ESR/EAR updates; later assignments override earlier ones, so the
    // order below runs from lowest to highest priority.
    always_comb begin
        msr_d = msr_q;
        esr_d = esr_q;
        ear_d = ear_q;
        if (!stall) begin
            if (msr_wr) begin
                msr_d = msr_wdata;
            end
            if (carry_we) begin
                msr_d[MSR_C]  = carry_val;
                msr_d[MSR_CM] = carry_val;
            end
            if (rtbd) begin
                msr_d[MSR_BIP] = 1'b0;
            end
            if (brk) begin
                msr_d[MSR_BIP] = 1'b1;
            end
            if (rtid) begin
                msr_d[MSR_IE] = 1'b1;
            end
            if (rted) begin
                msr_d[MSR_EIP] = 1'b0;
                msr_d[MSR_EE]  = 1'b1;
                esr_d          = '0;
            end
            if (exc_take) begin
                msr_d[MSR_EIP] = 1'b1;
                msr_d[MSR_EE]  = 1'b0;
                esr_d          = '0;
                esr_d[4:0]     = exc_align ? ESR_EC_ALIGN : ESR_EC_OPCODE;
                esr_d[ESR_DS]  = in_delay_slot;
                ear_d          = exc_addr;
            end
            if (int_take) begin
                msr_d[MSR_IE] = 1'b0;
            end
        end
    end

    // State registers; reset drops any outstanding request immediately.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            vec_q   <= '0;
            link_q  <= '0;
            id_q    <= '0;
            msr_q   <= MSR_RESET;
            esr_q   <= '0;
            ear_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            vec_q   <= vec_d;
            link_q  <= link_d;
            id_q    <= id_d;
            msr_q   <= msr_d;
            esr_q   <= esr_d;
            ear_q   <= ear_d;
        end
    end

    assign insert_req    = req_q;
    assign insert_vector = vec_q;
    assign insert_link   = link_q;
    assign irq_id        = id_q;
    assign msr           = msr_q;
    assign esr           = esr_q;
    assign ear           = ear_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_openfire_exc_ctrl.sv
// Directed bench for openfire_exc_ctrl. Line 1 is edge mode, the rest level.
module tb_openfire_exc_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic [3:0]  irq = '0;
    logic        exc_align = 1'b0;
    logic        exc_opcode = 1'b0;
    logic [31:0] exc_addr = '0;
    logic        in_delay_slot = 1'b0;
    logic        msr_wr = 1'b0;
    logic [31:0] msr_wdata = '0;
    logic        carry_we = 1'b0;
    logic        carry_val = 1'b0;
    logic        brk = 1'b0;
    logic        rtbd = 1'b0;
    logic        rtid = 1'b0;
    logic        rted = 1'b0;
    logic        insert_ack = 1'b0;
    logic        insert_req;
    logic [31:0] insert_vector;
    logic [4:0]  insert_link;
    logic [1:0]  irq_id;
    logic [31:0] msr;
    logic [31:0] esr;
    logic [31:0] ear;
    logic [1:0]  dbg_state;

    int n_assert = 0;
    int n_fail   = 0;

`ifdef OPENFIRE_VECTORED_IRQ_EN
    localparam logic [31:0] EXP_VEC_IRQ2 = 32'h60;
    localparam logic [31:0] EXP_VEC_IRQ0 = 32'h50;
    localparam logic [31:0] EXP_VEC_IRQ1 = 32'h58;
`else
    localparam logic [31:0] EXP_VEC_IRQ2 = 32'h10;
    localparam logic [31:0] EXP_VEC_IRQ0 = 32'h10;
    localparam logic [31:0] EXP_VEC_IRQ1 = 32'h10;
`endif

    openfire_exc_ctrl #(
        .NUM_IRQ      (4),
        .IRQ_ID_W     (2),
        .IRQ_EDGE     (4'b0010),
        .ADDR_W       (32),
        .INT_VECTOR   (32'h10),
        .IRQ_VEC_BASE (32'h50),
        .EXC_VECTOR   (32'h20)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .stall         (stall),
        .irq           (irq),
        .exc_align     (exc_align),
        .exc_opcode    (exc_opcode),
        .exc_addr      (exc_addr),
        .in_delay_slot (in_delay_slot),
        .msr_wr        (msr_wr),
        .msr_wdata     (msr_wdata),
        .carry_we      (carry_we),
        .carry_val     (carry_val),
        .brk           (brk),
        .rtbd          (rtbd),
        .rtid          (rtid),
        .rted          (rted),
        .insert_ack    (insert_ack),
        .insert_req    (insert_req),
        .insert_vector (insert_vector),
        .insert_link   (insert_link),
        .irq_id        (irq_id),
        .msr           (msr),
        .esr           (esr),
        .ear           (ear),
        .dbg_state     (dbg_state)
    );

    // Clock
    always #5 clock = ~clock;

    // Advance one clock; outputs are read 1 time unit after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        // 1. reset held, then released
        step();
        step();
        chk("rst_req",  {31'b0, insert_req}, 32'h0);
        chk("rst_msr",  msr, 32'h102);
        chk("rst_esr",  esr, 32'h0);
        chk("rst_ear",  ear, 32'h0);
        chk("rst_link", {27'b0, insert_link}, 32'h0);
        chk("rst_vec",  insert_vector, 32'h0);
        reset = 1'b1;
        step();
        chk("post_rst_msr", msr, 32'h102);
        chk("post_rst_esr", esr, 32'h0);
        chk("post_rst_req", {31'b0, insert_req}, 32'h0);

        // 2. level interrupt on line 2
        irq = 4'b0100;
        step();
        irq = 4'b0000;
        chk("int2_req",  {31'b0, insert_req}, 32'h1);
        chk("int2_id",   {30'b0, irq_id}, 32'h2);
        chk("int2_link", {27'b0, insert_link}, 32'd14);
        chk("int2_msr",  msr, 32'h100);
        chk("int2_vec",  insert_vector, EXP_VEC_IRQ2);
        chk("int2_state", {30'b0, dbg_state}, 32'h1);
        insert_ack = 1'b1;
        step();
        insert_ack = 1'b0;
        chk("int2_ack_req", {31'b0, insert_req}, 32'h0);
        chk("int2_ack_state", {30'b0, dbg_state}, 32'h0);
        rtid = 1'b1;
        step();
        rtid = 1'b0;
        chk("rtid_msr", msr, 32'h102);

        // 3. alignment exception in a delay slot
        exc_align = 1'b1;
        in_delay_slot = 1'b1;
        exc_addr = 32'h1003;
        step();
        exc_align = 1'b0;
        in_delay_slot = 1'b0;
        exc_addr = 32'h0;
        chk("align_esr",  esr, 32'h1001);
        chk("align_ear",  ear, 32'h1003);
        chk("align_msr",  msr, 32'h202);
        chk("align_vec",  insert_vector, 32'h20);
        chk("align_link", {27'b0, insert_link}, 32'd17);
        chk("align_req",  {31'b0, insert_req}, 32'h1);
        insert_ack = 1'b1;
        step();
        insert_ack = 1'b0;
        chk("align_ack_req", {31'b0, insert_req}, 32'h0);
        // a second exception while EIP=1 is dropped
        exc_opcode = 1'b1;
        exc_addr = 32'hDEAD;
        step();
        exc_opcode = 1'b0;
        chk("drop_req", {31'b0, insert_req}, 32'h0);
        chk("drop_ear", ear, 32'h1003);
        chk("drop_esr", esr, 32'h1001);
        rted = 1'b1;
        step();
        rted = 1'b0;
        chk("rted_esr", esr, 32'h0);
        chk("rted_msr", msr, 32'h102);

        // 4. opcode exception and irq[0] in the same cycle
        exc_opcode = 1'b1;
        irq = 4'b0001;
        step();
        exc_opcode = 1'b0;
        chk("both_link", {27'b0, insert_link}, 32'd17);
        chk("both_esr",  esr, 32'h2);
        chk("both_state", {30'b0, dbg_state}, 32'h2);
        insert_ack = 1'b1;
        step();
        insert_ack = 1'b0;
        chk("both_ack_req", {31'b0, insert_req}, 32'h0);
        step();
        step();
        chk("eip_block_req", {31'b0, insert_req}, 32'h0);
        rted = 1'b1;
        step();
        rted = 1'b0;
        chk("both_rted_esr", esr, 32'h0);
        chk("both_rted_req", {31'b0, insert_req}, 32'h0);
        step();
        irq = 4'b0000;
        chk("irq0_req",  {31'b0, insert_req}, 32'h1);
        chk("irq0_id",   {30'b0, irq_id}, 32'h0);
        chk("irq0_link", {27'b0, insert_link}, 32'd14);
        chk("irq0_vec",  insert_vector, EXP_VEC_IRQ0);
        chk("irq0_msr",  msr, 32'h100);
        insert_ack = 1'b1;
        step();
        insert_ack = 1'b0;
        rtid = 1'b1;
        step();
        rtid = 1'b0;
        chk("irq0_rtid_msr", msr, 32'h102);

        // 5. edge line 1 pulses during stall
        stall = 1'b1;
        irq = 4'b0010;
        step();
        irq = 4'b0000;
        step();
        chk("stall_req", {31'b0, insert_req}, 32'h0);
        chk("stall_msr", msr, 32'h102);
        stall = 1'b0;
        step();
        chk("edge_req", {31'b0, insert_req}, 32'h1);
        chk("edge_id",  {30'b0, irq_id}, 32'h1);
        chk("edge_vec", insert_vector, EXP_VEC_IRQ1);
        stall = 1'b1;
        insert_ack = 1'b1;
        step();
        chk("edge_stall_ack_req", {31'b0, insert_req}, 32'h1);
        stall = 1'b0;
        step();
        insert_ack = 1'b0;
        chk("edge_ack_req", {31'b0, insert_req}, 32'h0);
        rtid = 1'b1;
        step();
        rtid = 1'b0;
        step();
        chk("edge_cleared_req", {31'b0, insert_req}, 32'h0);

        // reset asserted mid-request
        irq = 4'b0100;
        step();
        chk("pre_rst_req", {31'b0, insert_req}, 32'h1);
        reset = 1'b0;
        #1;
        chk("async_rst_req", {31'b0, insert_req}, 32'h0);
        chk("async_rst_msr", msr, 32'h102);
        irq = 4'b0000;
        #2;
        reset = 1'b1;
        step();

        // 6. full MSR write with simultaneous carry clear
        msr_wr = 1'b1;
        msr_wdata = 32'hFFFF_FFFF;
        carry_we = 1'b1;
        carry_val = 1'b0;
        step();
        msr_wr = 1'b0;
        carry_we = 1'b0;
        chk("msr_wr_carry", msr, 32'h7FFF_FFFB);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
